// File: rtl/axi_w_addr_router.sv
// axi_w_addr_router: single-outstanding AXI write router. Decodes AWADDR to
// slave 0, slave 1 or the misroute port (2), presents AW and W to the chosen
// port concurrently, and returns that port's B response upstream.
module axi_w_addr_router #(
  parameter int AXI_ID_WIDTH     = 1,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int AXI_ADDR_WIDTH   = 8,
  parameter int AXI_AWCHAN_WIDTH = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 13,
  parameter int AXI_WDCHAN_WIDTH = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + 1,
  parameter int AXI_WBCHAN_WIDTH = AXI_ID_WIDTH + 2,
  parameter logic [AXI_ADDR_WIDTH-1:0] SLV0_BASE = 8'h00,
  parameter logic [AXI_ADDR_WIDTH-1:0] SLV0_MASK = 8'hC0,
  parameter logic [AXI_ADDR_WIDTH-1:0] SLV1_BASE = 8'h40,
  parameter logic [AXI_ADDR_WIDTH-1:0] SLV1_MASK = 8'hC0
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [AXI_AWCHAN_WIDTH-1:0]   S_AXI_AWCH_i,
  input  logic                          S_AXI_AWCH_VALID_i,
  output logic                          S_AXI_AWCH_READY_o,
  input  logic [AXI_WDCHAN_WIDTH-1:0]   S_AXI_WCH_i,
  input  logic                          S_AXI_WCH_VALID_i,
  output logic                          S_AXI_WCH_READY_o,
  output logic [AXI_WBCHAN_WIDTH-1:0]   S_AXI_BCH_o,
  output logic                          S_AXI_BCH_VALID_o,
  input  logic                          S_AXI_BCH_READY_i,
  output logic [3*AXI_AWCHAN_WIDTH-1:0] M_AXI_AWCH_o,
  output logic [2:0]                    M_AXI_AWCH_VALID_o,
  input  logic [2:0]                    M_AXI_AWCH_READY_i,
  output logic [3*AXI_WDCHAN_WIDTH-1:0] M_AXI_WCH_o,
  output logic [2:0]                    M_AXI_WCH_VALID_o,
  input  logic [2:0]                    M_AXI_WCH_READY_i,
  input  logic [3*AXI_WBCHAN_WIDTH-1:0] M_AXI_BCH_i,
  input  logic [2:0]                    M_AXI_BCH_VALID_i,
  output logic [2:0]                    M_AXI_BCH_READY_o,
  output logic [7:0]                    MISROUTE_CNT_o
);

  typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;

  state_t                        state, state_nxt;
  logic [AXI_AWCHAN_WIDTH-1:0]   aw_reg;
  logic [1:0]                    sel, sel_dec;
  logic                          aw_done, w_done;
  logic [7:0]                    cnt;
  logic [AXI_ADDR_WIDTH-1:0]     addr_in;
  logic                          aw_hs, w_last_hs;
  logic                          s_aw_ready, s_w_ready, s_b_valid;
  logic [AXI_WBCHAN_WIDTH-1:0]   s_b;
  logic [2:0]                    m_aw_valid, m_w_valid, m_b_ready;

  assign addr_in = S_AXI_AWCH_i[AXI_AWCHAN_WIDTH-AXI_ID_WIDTH-1:13];

  // Fixed-priority address decode: port 0, then port 1, else misroute port.
  always_comb begin
    sel_dec = 2'd2;
    if ((addr_in & SLV0_MASK) == SLV0_BASE)      sel_dec = 2'd0;
    else if ((addr_in & SLV1_MASK) == SLV1_BASE) sel_dec = 2'd1;
  end

  // Next-state and handshake steering; everything is forced low during reset.
  always_comb begin
    state_nxt  = state;
    s_aw_ready = 1'b0;
    s_w_ready  = 1'b0;
    s_b_valid  = 1'b0;
    s_b        = '0;
    m_aw_valid = '0;
    m_w_valid  = '0;
    m_b_ready  = '0;
    aw_hs      = 1'b0;
    w_last_hs  = 1'b0;
    if (!ARESET) begin
      case (state)
        IDLE: begin
          s_aw_ready = 1'b1;
          if (S_AXI_AWCH_VALID_i) state_nxt = FWD;
        end
        FWD: begin
          for (int unsigned k = 0; k < 3; k++) begin
            if (sel == 2'(k)) begin
              m_aw_valid[k] = !aw_done;
              m_w_valid[k]  = S_AXI_WCH_VALID_i && !w_done;
              s_w_ready     = M_AXI_WCH_READY_i[k] && !w_done;
              aw_hs         = !aw_done && M_AXI_AWCH_READY_i[k];
            end
          end
          w_last_hs = S_AXI_WCH_VALID_i && s_w_ready && S_AXI_WCH_i[0];
          // Same-cycle handshakes count, so AW and WLAST may finish together.
          if ((aw_done || aw_hs) && (w_done || w_last_hs)) state_nxt = RESP;
        end
        RESP: begin
          for (int unsigned k = 0; k < 3; k++) begin
            if (sel == 2'(k)) begin
              s_b          = M_AXI_BCH_i[k*AXI_WBCHAN_WIDTH +: AXI_WBCHAN_WIDTH];
              s_b_valid    = M_AXI_BCH_VALID_i[k];
              m_b_ready[k] = S_AXI_BCH_READY_i;
            end
          end
          if (s_b_valid && S_AXI_BCH_READY_i) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, captured AW, completion flags and saturating misroute counter.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      aw_reg  <= '0;
      sel     <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && S_AXI_AWCH_VALID_i) begin
        aw_reg  <= S_AXI_AWCH_i;
        sel     <= sel_dec;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (sel_dec == 2'd2 && cnt != 8'hFF) cnt <= cnt + 8'd1;
      end
      if (aw_hs)     aw_done <= 1'b1;
      if (w_last_hs) w_done  <= 1'b1;
    end
  end

  assign S_AXI_AWCH_READY_o = s_aw_ready;
  assign S_AXI_WCH_READY_o  = s_w_ready;
  assign S_AXI_BCH_o        = s_b;
  assign S_AXI_BCH_VALID_o  = s_b_valid;
  assign M_AXI_AWCH_VALID_o = m_aw_valid;
  assign M_AXI_WCH_VALID_o  = m_w_valid;
  assign M_AXI_BCH_READY_o  = m_b_ready;
  assign M_AXI_AWCH_o       = ARESET ? '0 : {3{aw_reg}};
  assign M_AXI_WCH_o        = ARESET ? '0 : {3{S_AXI_WCH_i}};
  assign MISROUTE_CNT_o     = ARESET ? '0 : cnt;

endmodule

// File: tb/tb_axi_w_addr_router.sv
// Directed bench for axi_w_addr_router: routing, W stalls, same-cycle
// AW/WLAST completion, misroute counter saturation and mid-burst reset.
module tb_axi_w_addr_router;

  logic         clk = 1'b0;
  logic         areset;
  logic [21:0]  s_aw;
  logic         s_aw_valid, s_aw_ready;
  logic [36:0]  s_w;
  logic         s_w_valid, s_w_ready;
  logic [2:0]   s_b;
  logic         s_b_valid, s_b_ready;
  logic [65:0]  m_aw;
  logic [2:0]   m_aw_valid, m_aw_ready;
  logic [110:0] m_w;
  logic [2:0]   m_w_valid, m_w_ready;
  logic [8:0]   m_b;
  logic [2:0]   m_b_valid, m_b_ready;
  logic [7:0]   mis_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_w_addr_router dut (
    .ACLK(clk), .ARESET(areset),
    .S_AXI_AWCH_i(s_aw), .S_AXI_AWCH_VALID_i(s_aw_valid), .S_AXI_AWCH_READY_o(s_aw_ready),
    .S_AXI_WCH_i(s_w), .S_AXI_WCH_VALID_i(s_w_valid), .S_AXI_WCH_READY_o(s_w_ready),
    .S_AXI_BCH_o(s_b), .S_AXI_BCH_VALID_o(s_b_valid), .S_AXI_BCH_READY_i(s_b_ready),
    .M_AXI_AWCH_o(m_aw), .M_AXI_AWCH_VALID_o(m_aw_valid), .M_AXI_AWCH_READY_i(m_aw_ready),
    .M_AXI_WCH_o(m_w), .M_AXI_WCH_VALID_o(m_w_valid), .M_AXI_WCH_READY_i(m_w_ready),
    .M_AXI_BCH_i(m_b), .M_AXI_BCH_VALID_i(m_b_valid), .M_AXI_BCH_READY_o(m_b_ready),
    .MISROUTE_CNT_o(mis_cnt)
  );

  function automatic logic [21:0] mk_aw(input logic id, input logic [7:0] addr, input logic [7:0] len);
    return {id, addr, len, 3'b010, 2'b01};
  endfunction

  function automatic logic [36:0] mk_w(input logic [31:0] data, input logic last);
    return {data, 4'hF, last};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic misroute_burst();
    s_aw = mk_aw(1'b0, 8'hFF, 8'd0); s_aw_valid = 1'b1;
    step();
    s_aw_valid = 1'b0; s_w = mk_w(32'h0, 1'b1); s_w_valid = 1'b1;
    m_aw_ready = 3'b100; m_w_ready = 3'b100;
    step();
    s_w_valid = 1'b0; m_aw_ready = 3'b000; m_w_ready = 3'b000;
    m_b = {3'b110, 6'b0}; m_b_valid = 3'b100; s_b_ready = 1'b1;
    step();
    m_b_valid = 3'b000; s_b_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    areset = 1'b1; s_aw = '0; s_aw_valid = 1'b0; s_w = '0; s_w_valid = 1'b0;
    s_b_ready = 1'b0; m_aw_ready = '0; m_w_ready = '0; m_b = '0; m_b_valid = '0;

    // Reset state
    step(); step();
    s_aw_valid = 1'b1; s_w_valid = 1'b1; settle();
    chk("rst_aw_ready", s_aw_ready, 1'b0);
    chk("rst_m_aw", m_aw, '0);
    chk("rst_cnt", mis_cnt, 8'h00);
    s_aw_valid = 1'b0; s_w_valid = 1'b0;
    step();
    areset = 1'b0; settle();
    chk("idle_aw_ready", s_aw_ready, 1'b1);
    chk("idle_w_ready", s_w_ready, 1'b0);

    // Burst to port 0, 4 beats
    m_aw_ready = 3'b001; m_w_ready = 3'b001;
    s_aw = mk_aw(1'b0, 8'h10, 8'd3); s_aw_valid = 1'b1;
    step();
    s_aw_valid = 1'b0; s_w = mk_w(32'hA0A0_0000, 1'b0); s_w_valid = 1'b1; settle();
    chk("p0_aw_valid", m_aw_valid, 3'b001);
    chk("p0_aw_data", m_aw[21:0], {1'b0, 8'h10, 8'd3, 3'b010, 2'b01});
    chk("p0_w_valid", m_w_valid, 3'b001);
    chk("p0_w_data", m_w[36:0], {32'hA0A0_0000, 4'hF, 1'b0});
    chk("p0_w_ready", s_w_ready, 1'b1);
    chk("p0_aw_ready_fwd", s_aw_ready, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step();
      s_w = mk_w(32'hA0A0_0000 + 32'(i), i == 3); settle();
      chk("p0_aw_valid_done", m_aw_valid, 3'b000);
      chk("p0_w_valid_beat", m_w_valid, 3'b001);
    end
    step();
    s_w_valid = 1'b0;
    m_b = {3'b101, 3'b111, 3'b010}; m_b_valid = 3'b111; s_b_ready = 1'b1; settle();
    chk("p0_b_valid", s_b_valid, 1'b1);
    chk("p0_b_data", s_b, 3'b010);
    chk("p0_b_ready", m_b_ready, 3'b001);
    chk("p0_w_ready_resp", s_w_ready, 1'b0);
    step();
    m_b_valid = 3'b000; s_b_ready = 1'b0; settle();
    chk("p0_back_idle", s_aw_ready, 1'b1);
    chk("p0_b_ready_idle", m_b_ready, 3'b000);

    // Port 1 with AW ready delayed, W finishing first
    m_aw_ready = 3'b000; m_w_ready = 3'b010;
    s_aw = mk_aw(1'b0, 8'h55, 8'd1); s_aw_valid = 1'b1;
    step();
    s_aw_valid = 1'b0; s_w = mk_w(32'h1111_0000, 1'b0); s_w_valid = 1'b1; settle();
    chk("p1_aw_valid", m_aw_valid, 3'b010);
    chk("p1_w_valid", m_w_valid, 3'b010);
    step();
    s_w = mk_w(32'h1111_0001, 1'b1); settle();
    chk("p1_w_last_ready", s_w_ready, 1'b1);
    step();
    settle();
    chk("p1_w_ready_done", s_w_ready, 1'b0);
    chk("p1_w_valid_done", m_w_valid, 3'b000);
    chk("p1_aw_held", m_aw_valid, 3'b010);
    step(); step();
    m_aw_ready = 3'b010; settle();
    chk("p1_aw_held2", m_aw_valid, 3'b010);
    chk("p1_no_b_yet", s_b_valid, 1'b0);
    step();
    m_aw_ready = 3'b000; s_w_valid = 1'b0; m_b = {3'b000, 3'b011, 3'b000}; settle();
    chk("p1_resp_b_wait", s_b_valid, 1'b0);
    m_b_valid = 3'b010; settle();
    chk("p1_b_valid", s_b_valid, 1'b1);
    chk("p1_b_data", s_b, 3'b011);
    chk("p1_b_ready_low", m_b_ready, 3'b000);
    step();
    s_b_ready = 1'b1; settle();
    chk("p1_b_ready", m_b_ready, 3'b010);
    step();
    m_b_valid = 3'b000; s_b_ready = 1'b0; m_w_ready = 3'b000; settle();
    chk("p1_back_idle", s_aw_ready, 1'b1);

    // Misroute: AW and WLAST in the same cycle
    s_aw = mk_aw(1'b1, 8'hA0, 8'd0); s_aw_valid = 1'b1;
    step();
    s_aw_valid = 1'b0; s_w = mk_w(32'hDEAD_BEEF, 1'b1); s_w_valid = 1'b1;
    m_aw_ready = 3'b100; m_w_ready = 3'b100; settle();
    chk("p2_aw_valid", m_aw_valid, 3'b100);
    chk("p2_w_valid", m_w_valid, 3'b100);
    chk("p2_w_ready", s_w_ready, 1'b1);
    step();
    s_w_valid = 1'b0; m_aw_ready = 3'b000; m_w_ready = 3'b000;
    m_b = {3'b111, 3'b000, 3'b000}; m_b_valid = 3'b100; s_b_ready = 1'b1; settle();
    chk("p2_resp_same_cycle", s_b_valid, 1'b1);
    chk("p2_b_data", s_b, 3'b111);
    chk("p2_cnt", mis_cnt, 8'd1);
    step();
    m_b_valid = 3'b000; s_b_ready = 1'b0; settle();
    chk("p2_back_idle", s_aw_ready, 1'b1);

    // W valid before AW stalls until FWD
    s_w = mk_w(32'h2222_2222, 1'b1); s_w_valid = 1'b1; m_w_ready = 3'b001;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("early_w_ready", s_w_ready, 1'b0);
      chk("early_w_valid", m_w_valid, 3'b000);
      step();
    end
    s_aw = mk_aw(1'b0, 8'h20, 8'd0); s_aw_valid = 1'b1; settle();
    chk("early_w_ready_aw", s_w_ready, 1'b0);
    step();
    s_aw_valid = 1'b0; m_aw_ready = 3'b001; settle();
    chk("early_w_fwd_ready", s_w_ready, 1'b1);
    chk("early_w_fwd_valid", m_w_valid, 3'b001);
    step();
    s_w_valid = 1'b0; m_aw_ready = 3'b000; m_w_ready = 3'b000;
    m_b = 9'b0; m_b_valid = 3'b001; s_b_ready = 1'b1; settle();
    chk("early_w_resp", s_b_valid, 1'b1);
    step();
    m_b_valid = 3'b000; s_b_ready = 1'b0;

    // Reset during beat 2 of 4
    m_w_ready = 3'b001;
    s_aw = mk_aw(1'b0, 8'h30, 8'd3); s_aw_valid = 1'b1;
    step();
    s_aw_valid = 1'b0; s_w = mk_w(32'h0, 1'b0); s_w_valid = 1'b1;
    step();
    s_w = mk_w(32'h1, 1'b0);
    step();
    s_w = mk_w(32'h2, 1'b0); areset = 1'b1; s_aw_valid = 1'b1; settle();
    chk("mid_rst_aw_valid", m_aw_valid, 3'b000);
    chk("mid_rst_w_valid", m_w_valid, 3'b000);
    chk("mid_rst_w_ready", s_w_ready, 1'b0);
    chk("mid_rst_aw_ready", s_aw_ready, 1'b0);
    chk("mid_rst_cnt", mis_cnt, 8'd0);
    step();
    areset = 1'b0; s_aw_valid = 1'b0; settle();
    chk("post_rst_aw_ready", s_aw_ready, 1'b1);
    chk("post_rst_w_valid", m_w_valid, 3'b000);
    chk("post_rst_cnt", mis_cnt, 8'd0);
    s_w_valid = 1'b0; m_w_ready = 3'b000;

    // Misroute counter saturation
    for (int i = 0; i < 255; i++) misroute_burst();
    settle();
    chk("sat_cnt_255", mis_cnt, 8'hFF);
    misroute_burst();
    settle();
    chk("sat_cnt_256", mis_cnt, 8'hFF);
    chk("sat_idle", s_aw_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
